// File: rtl/blackjack_pkg.sv
// Shared types for the blackjack datapath and control.
// The control FSM compares timer states against these names.
package blackjack_pkg;

    typedef enum logic [1:0] {
        T_IDLE = 2'd0,
        T_RUN  = 2'd1,
        T_DONE = 2'd2
    } timer_state_t;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counting delay timer with start/busy/done handshake.
// Decrements by DECREMENT per qualified tick, saturating at zero.
module countdown_timer
    import blackjack_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int DECREMENT = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_load,
    input  logic             i_tick,
    input  logic             i_enabled,
    input  logic             i_abort,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_value
);

    localparam logic [WIDTH-1:0] STEP = WIDTH'(DECREMENT);

    timer_state_t     state;
    timer_state_t     state_next;
    logic [WIDTH-1:0] value_next;
    logic             qualified;

    assign qualified = i_tick && i_enabled;

    // Next state and next count: abort beats start, start beats tick.
    always_comb begin
        state_next = state;
        value_next = o_value;
        if (i_abort) begin
            state_next = T_IDLE;
            value_next = '0;
        end else if (i_start) begin
            value_next = i_load;
            state_next = (i_load != '0) ? T_RUN : T_DONE;
        end else begin
            case (state)
                T_RUN: begin
                    if (qualified) begin
                        // Compare first so the subtraction never borrows.
                        if (o_value <= STEP) begin
                            value_next = '0;
                            state_next = T_DONE;
                        end else begin
                            value_next = o_value - STEP;
                        end
                    end
                end
                T_DONE: begin
                    state_next = T_IDLE;
                end
                T_IDLE: begin
                    state_next = T_IDLE;
                end
                default: begin
                    state_next = T_IDLE;
                    value_next = '0;
                end
            endcase
        end
    end

    // State, count and registered done pulse.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state   <= T_IDLE;
            o_value <= '0;
            o_done  <= 1'b0;
        end else begin
            state   <= state_next;
            o_value <= value_next;
            o_done  <= (state_next == T_DONE);
        end
    end

    // Busy is a pure decode of the registered state.
    always_comb begin
        o_busy = (state == T_RUN);
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counting delay timer: loads a start value, decrements it by DECREMENT on each qualified tick, and pulses o_done for exactly one cycle when it reaches zero. It is the downward counterpart of the team's free-running up-counter. The up-counter's one-cycle hit-top pulse drives i_tick, and the blackjack control FSM uses this block for dealer pacing and display hold delays via a start/busy/done handshake.

## Interface
- WIDTH, 16, width of load value and count.
- DECREMENT, 1, amount subtracted per qualified tick; must be ≥1 and < 2^WIDTH.

- i_clk  in  1  clock; all state changes on rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_start  in  1  one-cycle request to load i_load and begin counting.
- i_load  in  WIDTH  start value, sampled only on the edge where i_start is accepted.
- i_tick  in  1  count strobe, typically a one-cycle pulse.
- i_enabled  in  1  high enables counting; low freezes the count.
- i_abort  in  1  cancel the current count without a done pulse.
- o_busy  out  1  high while in RUN.
- o_done  out  1  one-cycle completion pulse, registered.
- o_value  out  WIDTH  current remaining count, registered.

## Operation
- Reset, asynchronous: state IDLE, o_value=0, o_busy=0, o_done=0.
- States are IDLE, RUN and DONE. o_busy is high only in RUN. o_done is high only in DONE.
- Edge priority, evaluated in every state: i_abort, then i_start, then tick.
- i_abort: o_value←0, next state IDLE, no o_done. An i_start in the same cycle is dropped.
- i_start, when not aborting, is accepted in IDLE, RUN (restart) or DONE:
  - o_value←i_load.
  - Next state is RUN if i_load≠0.
  - Next state is DONE if i_load=0, giving an immediate done pulse.
- RUN with no start/abort:
  - The count updates only when i_tick && i_enabled.
  - If o_value ≤ DECREMENT: o_value←0 and next state DONE (saturating; never wraps).
  - Otherwise o_value←o_value−DECREMENT and stay in RUN.
- A tick arriving with i_enabled low is ignored, not stored.
- A tick in the same cycle as an accepted start is ignored; the loaded value is not decremented.
- DONE lasts exactly one cycle, then goes to IDLE with o_value holding 0. An i_start in that cycle is accepted as above.
- In IDLE, o_value holds its last value (0 after completion or abort). Ticks are ignored.
- Width rule: the subtraction compares before subtracting, so no borrow reaches o_value.

## Timing
- i_start accepted at edge k: o_value=i_load and o_busy=1 from edge k.
- Ticks every cycle, DECREMENT=1, load N≥1:
  - o_value reaches 0 at edge k+N.
  - o_done is high for the cycle after edge k+N; o_busy drops at edge k+N.
  - o_done falls at edge k+N+1.
- Load 0: o_done is high for the cycle after edge k; o_busy never rises.
- Latency from the final qualifying tick to o_done is one edge. o_done and o_busy are never high together.
- Reset mid-RUN or mid-DONE clears all outputs immediately, without waiting for a clock. No done pulse is emitted.

## Structure
- Shared package blackjack_pkg holds typedef enum logic [1:0] timer_state_t {T_IDLE, T_RUN, T_DONE}. The package is shared with the control FSM, which compares against these names.
- No sub-module inside this block. The tick source, the up-counter, is instantiated at the top level and wired to i_tick.
- Implementation is one always_ff for state, o_value and o_done, plus combinational next-state logic.

## Test plan
- Reset, then load 5 with i_tick every cycle and DECREMENT=1 → o_value 5,4,3,2,1,0; o_done exactly one cycle, 5 edges after start; o_busy 1 for 5 cycles.
- Load 0 → o_done the next cycle, o_busy never 1. Load 7 with DECREMENT=3 → o_value 7,4,1,0 (saturates), then o_done once.
- Load 4, hold i_enabled low for 3 ticks mid-count, ticks every 4 cycles → o_value frozen while disabled; done arrives after exactly 4 qualified ticks.
- Load 10; after 3 ticks assert i_start with i_load=2 and i_tick together → o_value=2 (tick ignored), then done after 2 more ticks. Assert i_abort with i_start at value 6 → IDLE, o_value 0, no o_done.
- Assert async i_reset between clock edges at o_value=3 in RUN → outputs 0 immediately. Release reset → IDLE; ticks cause no change until the next i_start.
